// File: rtl/pid_loop_pkg.sv
// pid_loop_pkg: shared FSM state type and accumulator width rule for pid_loop
package pid_loop_pkg;

    typedef enum logic [2:0] {IDLE, SAT, MUL, SUM, OUT} state_t;

    // Room for the P, I and D products (the D difference adds one bit) plus carries.
    function automatic int acc_w(input int err_w, input int gain_w);
        return err_w + gain_w + 3;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// pid_sat: symmetric signed saturation of a wide value to +/-(2^(OUT_W-1)-1)
//   din  : signed IN_W-bit value (IN_W >= OUT_W)
//   dout : signed OUT_W-bit saturated value
module pid_sat #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN = -MAX;

    assign dout = din > MAX ? MAX[OUT_W-1:0] : din < MIN ? MIN[OUT_W-1:0] : din[OUT_W-1:0];

endmodule

// File: rtl/pid_loop.sv
// pid_loop: five-state PID controller turning a phase error into a DAC/PWM duty
//   CLK_SYS, CLK_RST      : clock, asynchronous active-low reset
//   Measure_Phase/_Done   : signed phase sample and its one-cycle strobe
//   KP, KI, KD            : unsigned gains, captured with an accepted strobe
//   PWM_Duty, Duty_Valid  : duty output and its one-cycle update pulse
//   Led_Lock, Busy, Overrun : lock indicator, computation in progress, strobe dropped
//   Define PID_DERIV_EN to build the derivative (KD) term; otherwise KD is ignored.
module pid_loop
    import pid_loop_pkg::*;
#(
    parameter int PHASE_W     = 24,
    parameter int ERR_W       = 16,
    parameter int GAIN_W      = 16,
    parameter int OUT_W       = 16,
    parameter int FRAC_SH     = 8,
    parameter int INT_LIM     = 100,
    parameter int DUTY_CENTER = 32768,
    parameter int LOCK_THR    = 10,
    parameter int LOCK_CNT    = 16
) (
    input  logic               CLK_SYS,
    input  logic               CLK_RST,
    input  logic [PHASE_W-1:0] Measure_Phase,
    input  logic               Measure_Done,
    input  logic [GAIN_W-1:0]  KP,
    input  logic [GAIN_W-1:0]  KI,
    input  logic [GAIN_W-1:0]  KD,
    output logic [OUT_W-1:0]   PWM_Duty,
    output logic               Duty_Valid,
    output logic               Led_Lock,
    output logic               Busy,
    output logic               Overrun
);

    localparam int ACC_W = acc_w(ERR_W, GAIN_W);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic signed [ERR_W:0]   LIM_P  = (ERR_W+1)'(INT_LIM);
    localparam logic signed [ERR_W:0]   LIM_N  = -LIM_P;
    localparam logic signed [ERR_W-1:0] THR    = ERR_W'(LOCK_THR);
    localparam logic signed [ACC_W:0]   CENTER = (ACC_W+1)'(DUTY_CENTER);
    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(LOCK_CNT);

    state_t                    state;
    logic signed [PHASE_W-1:0] phase;
    logic [GAIN_W-1:0]         kp, ki;
    logic signed [ERR_W-1:0]   err, err_s, integ, integ_nxt, abs_err;
    logic signed [ERR_W:0]     isum;
    logic signed [ACC_W-1:0]   kp_x, ki_x, err_x, integ_x, prod_p, prod_i, acc, u;
    logic signed [ACC_W:0]     duty_raw;
    logic signed [OUT_W:0]     duty_sat;
    logic [OUT_W-1:0]          duty_nxt;
    logic [CNT_W-1:0]          lock_cnt, lock_nxt;

    pid_sat #(.IN_W(PHASE_W), .OUT_W(ERR_W)) u_err_sat (.din(phase), .dout(err_s));

    assign isum      = {integ[ERR_W-1], integ} + {err_s[ERR_W-1], err_s};
    assign integ_nxt = isum > LIM_P ? LIM_P[ERR_W-1:0] : isum < LIM_N ? LIM_N[ERR_W-1:0] : isum[ERR_W-1:0];

    // All products are formed at accumulator width so the sum needs no further extension.
    assign kp_x    = {{(ACC_W-GAIN_W){1'b0}}, kp};
    assign ki_x    = {{(ACC_W-GAIN_W){1'b0}}, ki};
    assign err_x   = {{(ACC_W-ERR_W){err[ERR_W-1]}}, err};
    assign integ_x = {{(ACC_W-ERR_W){integ[ERR_W-1]}}, integ};

`ifdef PID_DERIV_EN
    logic [GAIN_W-1:0]       kd;
    logic signed [ERR_W-1:0] err_prev;
    logic signed [ACC_W-1:0] kd_x, prev_x, prod_d;
    assign kd_x   = {{(ACC_W-GAIN_W){1'b0}}, kd};
    assign prev_x = {{(ACC_W-ERR_W){err_prev[ERR_W-1]}}, err_prev};
    assign acc    = prod_p + prod_i + prod_d;
`else
    logic unused_kd;
    assign unused_kd = ^KD;
    assign acc       = prod_p + prod_i;
`endif

    assign u        = acc >>> FRAC_SH;
    assign duty_raw = {u[ACC_W-1], u} + CENTER;

    // Symmetric saturation to OUT_W+1 signed bits, then negatives floor at zero.
    pid_sat #(.IN_W(ACC_W+1), .OUT_W(OUT_W+1)) u_duty_sat (.din(duty_raw), .dout(duty_sat));

    assign duty_nxt = duty_sat[OUT_W] ? '0 : duty_sat[OUT_W-1:0];
    assign abs_err  = err[ERR_W-1] ? -err : err;
    assign lock_nxt = abs_err <= THR ? (lock_cnt == CNT_MAX ? lock_cnt : lock_cnt + 1'b1) : '0;
    assign Overrun  = Measure_Done & Busy;

    // OUT-stage results are registered on entry to OUT so they are visible
    // during the Duty_Valid cycle, four cycles after the strobe.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state      <= IDLE;
            phase      <= '0;
            kp         <= '0;
            ki         <= '0;
            err        <= '0;
            integ      <= '0;
            prod_p     <= '0;
            prod_i     <= '0;
            lock_cnt   <= '0;
            PWM_Duty   <= OUT_W'(DUTY_CENTER);
            Duty_Valid <= 1'b0;
            Led_Lock   <= 1'b0;
            Busy       <= 1'b0;
`ifdef PID_DERIV_EN
            kd         <= '0;
            err_prev   <= '0;
            prod_d     <= '0;
`endif
        end else begin
            Duty_Valid <= 1'b0;
            case (state)
                IDLE: if (Measure_Done) begin
                    state <= SAT;
                    Busy  <= 1'b1;
                    phase <= Measure_Phase;
                    kp    <= KP;
                    ki    <= KI;
`ifdef PID_DERIV_EN
                    kd    <= KD;
`endif
                end
                SAT: begin
                    state <= MUL;
                    err   <= err_s;
                    integ <= integ_nxt;
                end
                MUL: begin
                    state  <= SUM;
                    prod_p <= kp_x * err_x;
                    prod_i <= ki_x * integ_x;
`ifdef PID_DERIV_EN
                    prod_d <= kd_x * (err_x - prev_x);
`endif
                end
                SUM: begin
                    state      <= OUT;
                    PWM_Duty   <= duty_nxt;
                    Duty_Valid <= 1'b1;
                    lock_cnt   <= lock_nxt;
                    Led_Lock   <= lock_nxt == CNT_MAX;
`ifdef PID_DERIV_EN
                    err_prev   <= err;
`endif
                end
                OUT: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_loop.sv
// tb_pid_loop: directed self-checking bench for pid_loop with a cycle-level reference model
module tb_pid_loop;

    localparam longint ERR_MAX = 32767;
    localparam longint I_LIM   = 100;
    localparam longint CENTER  = 32768;
    localparam longint D_MAX   = 65535;
    localparam longint THR     = 10;
    localparam longint LCNT    = 16;

    logic        CLK_SYS = 1'b0;
    logic        CLK_RST = 1'b0;
    logic [23:0] Measure_Phase = '0;
    logic        Measure_Done = 1'b0;
    logic [15:0] KP = 16'd1000;
    logic [15:0] KI = 16'd10;
    logic [15:0] KD = 16'd0;
    logic [15:0] PWM_Duty;
    logic        Duty_Valid, Led_Lock, Busy, Overrun;

    int n_pass = 0;
    int n_total = 0;
    int dv_count = 0;
    int ov_count = 0;

    // Reference model state: timer counts down the 4-cycle computation window.
    int     m_timer = 0;
    longint m_integ = 0, m_prev = 0, m_lcnt = 0, m_duty = CENTER, p_duty = CENTER;
    logic   m_lock = 1'b0, p_lock = 1'b0;

    pid_loop dut (
        .CLK_SYS(CLK_SYS), .CLK_RST(CLK_RST),
        .Measure_Phase(Measure_Phase), .Measure_Done(Measure_Done),
        .KP(KP), .KI(KI), .KD(KD),
        .PWM_Duty(PWM_Duty), .Duty_Valid(Duty_Valid), .Led_Lock(Led_Lock),
        .Busy(Busy), .Overrun(Overrun)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    function automatic longint floor_div(input longint s, input longint d);
        longint q;
        q = s / d;
        if (s % d != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge CLK_SYS or negedge CLK_RST) begin
        longint e, ni, s, nl;
        if (!CLK_RST) begin
            m_timer <= 0;
            m_integ <= 0;
            m_prev  <= 0;
            m_lcnt  <= 0;
            m_duty  <= CENTER;
            m_lock  <= 1'b0;
        end else if (m_timer > 0) begin
            m_timer <= m_timer - 1;
            if (m_timer == 2) begin
                m_duty <= p_duty;
                m_lock <= p_lock;
            end
        end else if (Measure_Done) begin
            e  = clampl(longint'($signed(Measure_Phase)), -ERR_MAX, ERR_MAX);
            ni = clampl(m_integ + e, -I_LIM, I_LIM);
`ifdef PID_DERIV_EN
            s  = longint'(KP) * e + longint'(KI) * ni + longint'(KD) * (e - m_prev);
`else
            s  = longint'(KP) * e + longint'(KI) * ni;
`endif
            nl = (e <= THR && e >= -THR) ? clampl(m_lcnt + 1, 0, LCNT) : 0;
            m_integ <= ni;
            m_prev  <= e;
            m_lcnt  <= nl;
            p_duty  <= clampl(CENTER + floor_div(s, 256), 0, D_MAX);
            p_lock  <= nl == LCNT;
            m_timer <= 4;
        end
    end

    always @(negedge CLK_SYS) begin
        #2;
        chk("duty_valid", Duty_Valid, m_timer == 1);
        chk("pwm_duty", PWM_Duty, m_duty);
        chk("led_lock", Led_Lock, m_lock);
        chk("busy", Busy, m_timer > 0);
        chk("overrun", Overrun, Measure_Done && m_timer > 0);
        dv_count += int'(Duty_Valid);
        ov_count += int'(Overrun);
    end

    task automatic send(input logic [23:0] ph, output logic lk);
        int lat;
        Measure_Phase = ph;
        Measure_Done  = 1'b1;
        @(negedge CLK_SYS);
        Measure_Done = 1'b0;
        lat = 1;
        while (!Duty_Valid && lat < 12) begin
            @(negedge CLK_SYS);
            lat++;
        end
        chk("latency", lat, 4);
        lk = Led_Lock;
        @(negedge CLK_SYS);
    endtask

    task automatic do_reset();
        CLK_RST = 1'b0;
        #1;
        chk("rst_duty", PWM_Duty, 32768);
        chk("rst_valid", Duty_Valid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_lock", Led_Lock, 0);
        repeat (2) @(negedge CLK_SYS);
        CLK_RST = 1'b1;
        @(negedge CLK_SYS);
    endtask

    initial begin
        logic lk;
        int   dv0, ov0;
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lk;
        int   dv0, ov0;
        @(negedge CLK_SYS);
        do_reset();

        send(24'd256, lk);
        chk("pos_duty", PWM_Duty, 33771);
        chk("pos_integ", $signed(dut.integ), 100);
        chk("model_pos_duty", m_duty, 33771);

        do_reset();
        send(-24'sd256, lk);
        chk("neg_duty", PWM_Duty, 31764);
        chk("neg_integ", $signed(dut.integ), -100);

        send(24'h7FFFFF, lk);
        chk("sat_hi_duty", PWM_Duty, 65535);
        send(24'h800000, lk);
        chk("sat_lo_duty", PWM_Duty, 0);

        Measure_Phase = 24'd256;
        Measure_Done  = 1'b1;
        @(negedge CLK_SYS);
        Measure_Done = 1'b0;
        @(negedge CLK_SYS);
        chk("mul_busy", Busy, 1);
        dv0 = dv_count;
        do_reset();
        repeat (6) @(negedge CLK_SYS);
        chk("abort_no_valid", dv_count - dv0, 0);
        chk("abort_duty", PWM_Duty, 32768);
        send(24'd256, lk);
        chk("after_abort_duty", PWM_Duty, 33771);

        do_reset();
        for (int i = 1; i <= 16; i++) begin
            send(24'd5, lk);
            chk($sformatf("lock_%0d", i), lk, i == 16);
        end
        send(24'd50, lk);
        chk("lock_drop", lk, 0);

        do_reset();
        dv0 = dv_count;
        ov0 = ov_count;
        Measure_Phase = 24'd50;
        Measure_Done  = 1'b1;
        @(negedge CLK_SYS);
        Measure_Done = 1'b0;
        @(negedge CLK_SYS);
        Measure_Done = 1'b1;
        #1;
        chk("overrun_pulse", Overrun, 1);
        @(negedge CLK_SYS);
        Measure_Done = 1'b0;
        repeat (8) @(negedge CLK_SYS);
        chk("overrun_count", ov_count - ov0, 1);
        chk("overrun_valid_count", dv_count - dv0, 1);
        chk("overrun_integ", $signed(dut.integ), 50);
        chk("overrun_duty", PWM_Duty, 32965);

        do_reset();
        KD = 16'd100;
        send(24'd0, lk);
        chk("deriv_first", PWM_Duty, 32768);
        send(24'd256, lk);
`ifdef PID_DERIV_EN
        chk("deriv_second", PWM_Duty, 33871);
`else
        chk("deriv_second", PWM_Duty, 33771);
`endif

        repeat (2) @(negedge CLK_SYS);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
